// File: rtl/dual_prio_pkg.sv
// Shared types and helpers for the dual priority decoder.
//   DEF_N / DEF_M : default grant width / code width
//   state_e       : decoder FSM states
//   pair_legal    : legality rule for an encoded (first, second) pair
//   code2onehot   : code k (1..ONEHOT_MAX) -> bit k-1 set, code 0 -> all zero
package dual_prio_pkg;

  localparam int DEF_N      = 12;
  localparam int DEF_M      = 4;
  // Widest one-hot vector code2onehot can build; callers size-cast down to N.
  localparam int ONEHOT_MAX = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT1 = 2'd1,
    BEAT2 = 2'd2
  } state_e;

  // Both codes in range, and a nonzero second code must rank strictly below
  // a nonzero first code (the encoder never emits second without first).
  function automatic logic pair_legal(input int unsigned f,
                                      input int unsigned s,
                                      input int unsigned n);
    return (f <= n) && (s <= n) && ((s == 0) || ((f != 0) && (s < f)));
  endfunction

  function automatic logic [ONEHOT_MAX-1:0] code2onehot(input int unsigned code);
    logic [ONEHOT_MAX-1:0] oh;
    oh = '0;
    if (code != 0 && code <= ONEHOT_MAX)
      oh[code-1] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/code_to_onehot.sv
// Combinational code -> one-hot expander.
//   code   in  M : code, 0 = none
//   onehot out N : bit code-1 set, all zero for code 0 or code > N
module code_to_onehot
  import dual_prio_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = DEF_M
) (
  input  logic [M-1:0] code,
  output logic [N-1:0] onehot
);

  // Codes above N land outside the truncated range and read as zero.
  assign onehot = N'(code2onehot(32'(code)));

endmodule

// File: rtl/dual_prio_decoder.sv
// Dual priority decoder: re-expands an encoded (first, second) code pair
// into one-hot grant beats on a valid/ready stream, first grant then second.
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : code pair handshake (ready only when idle)
//   first, second      : M-bit codes, 0 = none
//   out_valid/out_ready: grant beat handshake
//   grant              : N-bit one-hot grant, zero for empty/error beats
//   out_last           : final beat of the pair
//   err                : beat reports an illegal pair
//   err_count          : saturating illegal-pair count
// Optional feature: define DUALDEC_ERRCNT_EN to build the illegal-pair
// counter; otherwise err_count is tied to zero and no counter flops exist.
module dual_prio_decoder
  import dual_prio_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = DEF_M
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] first,
  input  logic [M-1:0] second,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] grant,
  output logic         out_last,
  output logic         err,
  output logic [7:0]   err_count
);

  state_e       state;
  logic [M-1:0] sec_q;
  logic [M-1:0] code_sel;
  logic [N-1:0] oh;
  logic         accept;
  logic         hs;
  logic         legal;

  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign hs       = out_valid && out_ready;
  assign legal    = pair_legal(32'(first), 32'(second), N);

  // One expander serves both beats: the live first code while idle, the
  // captured second code once the first beat is out.
  assign code_sel = (state == IDLE) ? first : sec_q;

  code_to_onehot #(.N(N), .M(M)) u_oh (
    .code   (code_sel),
    .onehot (oh)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      grant     <= '0;
      out_last  <= 1'b0;
      err       <= 1'b0;
      sec_q     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            out_valid <= 1'b1;
            sec_q     <= second;
            state     <= BEAT1;
            if (!legal) begin
              grant    <= '0;
              err      <= 1'b1;
              out_last <= 1'b1;
            end else begin
              grant    <= oh;
              err      <= 1'b0;
              out_last <= (second == '0);
            end
          end
        end
        BEAT1: begin
          if (hs) begin
            if (out_last) begin
              out_valid <= 1'b0;
              grant     <= '0;
              out_last  <= 1'b0;
              err       <= 1'b0;
              state     <= IDLE;
            end else begin
              grant    <= oh;
              out_last <= 1'b1;
              state    <= BEAT2;
            end
          end
        end
        BEAT2: begin
          if (hs) begin
            out_valid <= 1'b0;
            grant     <= '0;
            out_last  <= 1'b0;
            err       <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DUALDEC_ERRCNT_EN
  logic [7:0] err_cnt_q;

  // Counted at acceptance, not at beat delivery, so a pair dropped by
  // reset has already been counted (and is then cleared with everything).
  always_ff @(posedge clk) begin
    if (rst)
      err_cnt_q <= 8'h00;
    else if (accept && !legal && err_cnt_q != 8'hFF)
      err_cnt_q <= err_cnt_q + 8'h01;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_dual_prio_decoder.sv
// Scoreboard bench for dual_prio_decoder (N=12, M=4). Stimulus changes on
// the falling edge; the monitor samples 2 time units after it.
module tb_dual_prio_decoder;

  localparam int N = 12;
  localparam int M = 4;

  typedef struct {
    logic [N-1:0] g;
    logic         l;
    logic         e;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [M-1:0] first = '0;
  logic [M-1:0] second = '0;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] grant;
  logic         out_last;
  logic         err;
  logic [7:0]   err_count;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    errcnt_exp = 0;
  logic  rdy_mode = 1'b0;   // 0: random out_ready, 1: rdy_force
  logic  rdy_force = 1'b0;

  dual_prio_decoder #(.N(N), .M(M)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .first(first), .second(second), .out_valid(out_valid),
    .out_ready(out_ready), .grant(grant), .out_last(out_last),
    .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: what the consumer should see for one accepted pair.
  task automatic model(input int f, input int s);
    beat_t b;
    bit ok;
    ok = (f <= N) && (s <= N) && (s == 0 || (f != 0 && s < f));
    if (!ok) begin
      b.g = '0; b.l = 1'b1; b.e = 1'b1; exp_q.push_back(b);
`ifdef DUALDEC_ERRCNT_EN
      if (errcnt_exp < 255) errcnt_exp++;
`endif
    end else begin
      b.g = (f == 0) ? '0 : N'(1) << (f - 1);
      b.l = (s == 0); b.e = 1'b0; exp_q.push_back(b);
      if (s != 0) begin
        b.g = N'(1) << (s - 1); b.l = 1'b1; b.e = 1'b0; exp_q.push_back(b);
      end
    end
  endtask

  task automatic send_pair(input int f, input int s);
    int n;
    @(negedge clk);
    in_valid = 1'b1; first = M'(f); second = M'(s);
    n = 0;
    #1;
    while (!in_ready && n < 500) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0 for pair (%0d,%0d)", f, s);
    end else begin
      model(f, s);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 2000) begin
      @(negedge clk); #3; n++;
    end
    if (exp_q.size() != 0 || out_valid) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: %0d beats still expected", exp_q.size());
    end
  endtask

  // out_ready driver
  initial begin
    out_ready = 1'b0;
    forever begin
      @(negedge clk); #1;
      out_ready = rdy_mode ? rdy_force : ($urandom_range(0, 99) < 70);
    end
  end

  // Monitor: pops one expected beat per output handshake, checks stalls.
  initial begin
    bit held;
    logic [N+1:0] held_beat;
    beat_t e;
    held = 0;
    held_beat = '0;
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        held = 0;
      end else begin
        if (held) begin
          check("hold_valid", 32'(out_valid), 32'(1));
          if (out_valid) check("hold_beat", 32'({grant, out_last, err}), 32'(held_beat));
        end
        held = 0;
        if (out_valid) begin
          check("in_ready_busy", 32'(in_ready), 32'(0));
          if (out_ready) begin
            if (exp_q.size() == 0) begin
              n_checks++; n_fail++;
              $display("FAIL unexpected_beat: grant=%0h last=%0b err=%0b", grant, out_last, err);
            end else begin
              e = exp_q.pop_front();
              check("beat{grant,last,err}", 32'({grant, out_last, err}), 32'({e.g, e.l, e.e}));
            end
          end else begin
            held = 1;
            held_beat = {grant, out_last, err};
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f, s;
    // Reset state
    repeat (3) @(negedge clk);
    #3;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_grant", 32'(grant), 32'(0));
    check("rst_last_err", 32'({out_last, err}), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(0));
    check("rst_err_count", 32'(err_count), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    #1 check("in_ready_after_rst", 32'(in_ready), 32'(1));

    // Directed: two-beat, single-beat, empty, illegal pairs
    send_pair(9, 4);
    send_pair(12, 0);
    send_pair(0, 0);
    send_pair(5, 7);
    send_pair(0, 3);
    send_pair(13, 0);
    drain();
    check("err_count_directed", 32'(err_count), 32'(errcnt_exp));

    // Backpressure: each beat stalled 5 cycles
    rdy_mode = 1'b1; rdy_force = 1'b0;
    send_pair(9, 4);
    repeat (5) begin
      @(negedge clk); #3;
      check("stall1_grant", 32'({out_valid, grant, in_ready}), 32'({1'b1, 12'h100, 1'b0}));
    end
    rdy_force = 1'b1;
    @(negedge clk); #2;
    rdy_force = 1'b0;
    repeat (5) begin
      @(negedge clk); #3;
      check("stall2_grant", 32'({out_valid, grant, in_ready}), 32'({1'b1, 12'h008, 1'b0}));
    end
    rdy_force = 1'b1;
    drain();

    // Randomized pairs with random backpressure
    rdy_mode = 1'b0;
    repeat (200) begin
      if ($urandom_range(0, 1) == 1) begin
        f = $urandom_range(1, N);
        s = $urandom_range(0, f - 1);
      end else begin
        f = $urandom_range(0, 15);
        s = $urandom_range(0, 15);
      end
      send_pair(f, s);
    end
    drain();
    check("err_count_random", 32'(err_count), 32'(errcnt_exp));

    // Reset during the second beat drops it
    rdy_mode = 1'b1; rdy_force = 1'b0;
    send_pair(9, 4);
    rdy_force = 1'b1;
    @(negedge clk);
    rdy_force = 1'b0;
    #3 check("beat2_before_rst", 32'({out_valid, grant, out_last}), 32'({1'b1, 12'h008, 1'b1}));
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk); #3;
    check("rst_mid_valid", 32'(out_valid), 32'(0));
    check("rst_mid_in_ready", 32'(in_ready), 32'(0));
    errcnt_exp = 0;
    rst = 1'b0;
    #1 check("rst_mid_ready_after", 32'(in_ready), 32'(1));
    rdy_force = 1'b1;
    repeat (4) begin
      @(negedge clk); #3;
      check("no_beat_after_rst", 32'(out_valid), 32'(0));
    end

    // Counter saturation
    repeat (300) send_pair(5, 7);
    drain();
    check("err_count_sat", 32'(err_count), 32'(errcnt_exp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
